// File: rtl/i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_dac_tx
// Brief    : I2S stereo serializer slaved to codec BCLK/DACLRCK, with a
//            one-entry valid/ready holding buffer and an underrun counter.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_dac_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sample_left,
    input  logic [DATA_WIDTH-1:0] sample_right,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic                  frame_start,
    output logic [15:0]           underrun_count
);

    localparam int                CW              = $clog2(SLOT_BITS);
    localparam logic [CW-1:0]     c_CNT_MAX       = CW'(SLOT_BITS - 1);
    localparam logic [CW-1:0]     c_CNT_DATA_LAST = CW'(DATA_WIDTH);
    localparam logic [15:0]       c_UNDERRUN_MAX  = 16'hFFFF;

    localparam logic [1:0]        c_ST_SYNC  = 2'd0;
    localparam logic [1:0]        c_ST_LEFT  = 2'd1;
    localparam logic [1:0]        c_ST_RIGHT = 2'd2;

    logic                  r_bclk_s1, r_bclk_s2, r_bclk_d;
    logic                  r_lrck_s1, r_lrck_s2, r_lrck_prev;
    logic                  w_bclk_fall, w_boundary;

    logic [1:0]            r_state, w_state_next;
    logic                  w_load_frame, w_load_right, w_shift_en;

    logic [CW-1:0]         r_bit_cnt, w_cnt_next;
    logic [DATA_WIDTH-1:0] r_shift, r_right_hold;
    logic                  r_dacdat;
    logic                  r_frame_start;
    logic [15:0]           r_underrun;

    logic                  r_buf_full;
    logic [DATA_WIDTH-1:0] r_buf_l, r_buf_r;
    logic                  w_accept;

    // Codec clocks are asynchronous: two-flop synchronizers plus a BCLK delay tap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bclk_s1 <= 1'b0;
            r_bclk_s2 <= 1'b0;
            r_bclk_d  <= 1'b0;
            r_lrck_s1 <= 1'b0;
            r_lrck_s2 <= 1'b0;
        end else begin
            r_bclk_s1 <= AUD_BCLK;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_d  <= r_bclk_s2;
            r_lrck_s1 <= AUD_DACLRCK;
            r_lrck_s2 <= r_lrck_s1;
        end
    end

    assign w_bclk_fall = r_bclk_d & ~r_bclk_s2;
    assign w_boundary  = w_bclk_fall & (r_lrck_s2 != r_lrck_prev);
    assign w_cnt_next  = (r_bit_cnt == c_CNT_MAX) ? r_bit_cnt : r_bit_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_boundary) begin
            if (!r_lrck_s2) begin
                w_state_next = c_ST_LEFT;
            end else if (r_state != c_ST_SYNC) begin
                w_state_next = c_ST_RIGHT;
            end
        end
    end

    always_comb begin
        w_load_frame = w_boundary & ~r_lrck_s2;
        w_load_right = w_boundary & r_lrck_s2 & (r_state != c_ST_SYNC);
        w_shift_en   = w_bclk_fall & ~w_boundary & (r_state != c_ST_SYNC)
                       & (w_cnt_next <= c_CNT_DATA_LAST);
    end

    // Serial datapath; the boundary fall itself drives the one-bit delay slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lrck_prev  <= 1'b0;
            r_bit_cnt    <= '0;
            r_dacdat     <= 1'b0;
            r_shift      <= '0;
            r_right_hold <= '0;
        end else if (w_bclk_fall) begin
            r_lrck_prev <= r_lrck_s2;
            r_bit_cnt   <= w_boundary ? '0 : w_cnt_next;
            r_dacdat    <= w_shift_en ? r_shift[DATA_WIDTH-1] : 1'b0;
            if (w_load_frame) begin
                r_shift      <= r_buf_full ? r_buf_l : '0;
                r_right_hold <= r_buf_full ? r_buf_r : '0;
            end else if (w_load_right) begin
                r_shift <= r_right_hold;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign sample_ready = ~r_buf_full & ~reset;
    assign w_accept     = sample_valid & sample_ready;

    // An accept only happens when empty, so it never collides with a load that empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_full    <= 1'b0;
            r_buf_l       <= '0;
            r_buf_r       <= '0;
            r_frame_start <= 1'b0;
            r_underrun    <= '0;
        end else begin
            r_frame_start <= w_load_frame;
            if (w_load_frame) begin
                r_buf_full <= 1'b0;
                if (!r_buf_full && (r_underrun != c_UNDERRUN_MAX)) begin
                    r_underrun <= r_underrun + 16'd1;
                end
            end
            if (w_accept) begin
                r_buf_full <= 1'b1;
                r_buf_l    <= sample_left;
                r_buf_r    <= sample_right;
            end
        end
    end

    assign AUD_DACDAT     = r_dacdat;
    assign frame_start    = r_frame_start;
    assign underrun_count = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_dac_tx
// Brief    : Directed plus randomized bench for i2s_dac_tx with a frame-level
//            reference model of buffer, underrun count and serial bit stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_dac_tx;

    localparam int DW   = 24;
    localparam int SLOT = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] sample_left, sample_right;
    logic          sample_valid;
    logic          sample_ready;
    logic          AUD_BCLK, AUD_DACLRCK;
    logic          AUD_DACDAT;
    logic          frame_start;
    logic [15:0]   underrun_count;

    always #10 clk = ~clk;

    i2s_dac_tx #(.DATA_WIDTH(DW), .SLOT_BITS(SLOT)) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_left    (sample_left),
        .sample_right   (sample_right),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .AUD_BCLK       (AUD_BCLK),
        .AUD_DACLRCK    (AUD_DACLRCK),
        .AUD_DACDAT     (AUD_DACDAT),
        .frame_start    (frame_start),
        .underrun_count (underrun_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (frame level)
    logic          m_full, m_synced, m_prev, m_chan, m_fs, m_rst;
    logic [DW-1:0] m_bl, m_br, m_cur_l, m_cur_r;
    logic [15:0]   m_under;
    int            m_k;

    // Stimulus controls
    logic          p_cont;
    logic          ready_seen;
    int            arm_c;
    logic [DW-1:0] arm_l, arm_r;
    logic          rst_arm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit();
        if (!m_synced) return 1'b0;
        if (m_k >= 1 && m_k <= DW) return m_chan ? m_cur_r[DW-m_k] : m_cur_l[DW-m_k];
        return 1'b0;
    endfunction

    // What the block should do at the coming clock edge, given the current inputs.
    // A pin fall is acted upon three clocks after the pin edge.
    task automatic model_edge(input logic is_fall, input logic lr);
        logic acc;
        if (reset) begin
            m_full = 1'b0; m_under = '0; m_synced = 1'b0; m_prev = 1'b0;
            m_fs = 1'b0; m_rst = 1'b1; m_k = 0;
        end else begin
            m_rst = 1'b0;
            m_fs  = 1'b0;
            acc   = sample_valid && !m_full;
            if (is_fall) begin
                if (lr != m_prev) begin
                    m_k    = 0;
                    m_chan = lr;
                    if (!lr) begin
                        m_synced = 1'b1;
                        m_fs     = 1'b1;
                        if (m_full) begin
                            m_cur_l = m_bl; m_cur_r = m_br; m_full = 1'b0;
                        end else begin
                            m_cur_l = '0; m_cur_r = '0;
                            if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
                        end
                    end
                end else begin
                    m_k = (m_k < SLOT-1) ? m_k + 1 : SLOT-1;
                end
                m_prev = lr;
            end
            if (acc) begin
                m_full = 1'b1; m_bl = sample_left; m_br = sample_right;
            end
        end
    endtask

    task automatic tick(input logic is_fall, input logic lr);
        ready_seen = sample_ready;
        model_edge(is_fall, lr);
        @(posedge clk);
        @(negedge clk);
        chk("ready", 32'(sample_ready), 32'(!m_full && !reset));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("underrun", 32'(underrun_count), 32'(m_under));
        if (m_rst) chk("dacdat_in_reset", 32'(AUD_DACDAT), 32'd0);
        if (sample_valid && ready_seen) begin
            if (p_cont) begin
                sample_left  = sample_left + 24'd1;
                sample_right = sample_right + 24'd1;
            end else begin
                sample_valid = 1'b0;
            end
        end
    endtask

    // One BCLK period: fall (with LRCK change) at c=0, rise at c=8.
    task automatic do_bit(input logic lr);
        for (int c = 0; c < 16; c++) begin
            if (c == 0) begin
                AUD_BCLK    = 1'b0;
                AUD_DACLRCK = lr;
            end
            if (c == 8) begin
                chk("dacdat", 32'(AUD_DACDAT), 32'(exp_bit()));
                AUD_BCLK = 1'b1;
            end
            if (c == arm_c) begin
                sample_left  = arm_l;
                sample_right = arm_r;
                sample_valid = 1'b1;
                arm_c        = -1;
            end
            if (rst_arm && c == 9)  reset = 1'b1;
            if (rst_arm && c == 12) begin
                reset   = 1'b0;
                rst_arm = 1'b0;
            end
            tick(c == 2, lr);
        end
    endtask

    task automatic do_half(input logic lr);
        for (int b = 0; b < SLOT; b++) do_bit(lr);
    endtask

    task automatic do_frame();
        do_half(1'b0);
        do_half(1'b1);
    endtask

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        sample_left  = l;
        sample_right = r;
        sample_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1; AUD_BCLK = 1'b1; AUD_DACLRCK = 1'b1;
        sample_valid = 1'b0; sample_left = '0; sample_right = '0;
        p_cont = 1'b0; arm_c = -1; arm_l = '0; arm_r = '0; rst_arm = 1'b0;
        m_full = 1'b0; m_synced = 1'b0; m_prev = 1'b0; m_chan = 1'b0;
        m_fs = 1'b0; m_rst = 1'b1; m_under = '0; m_k = 0;
        m_bl = '0; m_br = '0; m_cur_l = '0; m_cur_r = '0;
        @(negedge clk);

        // Reset state
        repeat (4) tick(1'b0, 1'b1);
        reset = 1'b0;
        repeat (6) tick(1'b0, 1'b1);

        // Basic frame; leading right-slot bits exercise the ignored right boundary in SYNC
        push(24'hA5C3F1, 24'h123456);
        for (int b = 0; b < 4; b++) do_bit(1'b1);
        do_frame();
        chk("underrun_basic", 32'(underrun_count), 32'd0);

        // Underrun frames, then recovery
        repeat (3) do_frame();
        chk("underrun_three", 32'(underrun_count), 32'd3);
        push(24'h800001, 24'($urandom));
        do_frame();

        // Continuous producer with incrementing pairs
        push(24'($urandom), 24'($urandom));
        p_cont = 1'b1;
        repeat (3) do_frame();
        p_cont       = 1'b0;
        sample_valid = 1'b0;
        do_frame();

        // Accept in the same cycle as the left-boundary load
        arm_c = 2; arm_l = 24'($urandom); arm_r = 24'($urandom);
        do_frame();
        do_frame();

        // Randomized push timing and data
        for (int f = 0; f < 4; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                arm_c = $urandom_range(0, 15);
                arm_l = 24'($urandom);
                arm_r = 24'($urandom);
            end
            do_frame();
        end

        // Reset at bit 10 of a left slot
        push(24'($urandom), 24'($urandom));
        for (int b = 0; b < SLOT; b++) begin
            if (b == 10) rst_arm = 1'b1;
            do_bit(1'b0);
        end
        push(24'($urandom), 24'($urandom));
        do_half(1'b1);
        do_frame();
        chk("underrun_after_reset", 32'(underrun_count), 32'd0);

        // Saturation, with the count preloaded near the top
        force dut.r_underrun = 16'hFFFD;
        m_under = 16'hFFFD;
        tick(1'b0, 1'b1);
        release dut.r_underrun;
        tick(1'b0, 1'b1);
        repeat (4) do_frame();
        chk("underrun_saturated", 32'(underrun_count), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
